// File: rtl/ocs_ctrl_rx_parser.sv
// ocs_ctrl_rx_parser: decodes OCS control/time-sync frames from a 64-bit RX AXI-Stream (no backpressure).
// Inputs : i_clk, i_rst_n (async active-low), i_rx_axis_{tvalid,tdata,tlast,tkeep,tuser}
// Outputs: o_recv_time_stamp/o_recv_ts_valid (code 01), o_recv_return_ts/o_recv_return_valid (code 02),
//          o_recv_std_time/o_recv_std_valid (code 03), o_chnl_ready/o_cur_slot_id/o_syn_start (code 04),
//          o_good_cnt/o_drop_cnt (saturating frame counters)
module ocs_ctrl_rx_parser #(
  parameter logic [15:0] P_SLOT_ID_TYPE = 16'hff03,
  parameter logic [47:0] P_MY_MAC       = 48'h8DBC_5C4A_1A1F,
  parameter int          P_MIN_BEATS    = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx_axis_tvalid,
  input  logic [63:0] i_rx_axis_tdata,
  input  logic        i_rx_axis_tlast,
  input  logic [7:0]  i_rx_axis_tkeep,
  input  logic        i_rx_axis_tuser,
  output logic [63:0] o_recv_time_stamp,
  output logic        o_recv_ts_valid,
  output logic [63:0] o_recv_return_ts,
  output logic        o_recv_return_valid,
  output logic [63:0] o_recv_std_time,
  output logic        o_recv_std_valid,
  output logic [7:0]  o_chnl_ready,
  output logic        o_cur_slot_id,
  output logic        o_syn_start,
  output logic [15:0] o_good_cnt,
  output logic [15:0] o_drop_cnt
);
  typedef enum logic [2:0] {S_SYNC, S_IDLE, S_HDR1, S_PAYLOAD, S_DRAIN} state_t;
  state_t r_state, w_next;
  logic        r_mac_ok;
  logic [15:0] r_type;
  logic [7:0]  r_code, r_chnl, r_beats;
  logic [63:0] r_payload;
  logic        w_end, w_commit, w_short, w_good, w_drop, w_unused;
  logic [8:0]  w_cnt;
  logic [63:0] w_payload;
  assign w_end    = i_rx_axis_tvalid & i_rx_axis_tlast;
  assign w_commit = w_end & (r_state == S_PAYLOAD || r_state == S_DRAIN);
  assign w_short  = w_end & (r_state == S_IDLE || r_state == S_HDR1);
  // beats seen so far including the current tlast beat
  assign w_cnt     = {1'b0, r_beats} + 9'd1;
  // a frame ending on its payload beat commits straight from the bus
  assign w_payload = (r_state == S_PAYLOAD) ? i_rx_axis_tdata : r_payload;
  assign w_good    = w_commit & r_mac_ok & (r_type == P_SLOT_ID_TYPE) & (r_code >= 8'h01) &
                     (r_code <= 8'h04) & ~i_rx_axis_tuser & (w_cnt >= 9'(P_MIN_BEATS));
  assign w_drop    = w_short | (w_commit & ~w_good);
  assign w_unused  = ^i_rx_axis_tkeep;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_SYNC;
    else          r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (i_rx_axis_tvalid)
      case (r_state)
        S_SYNC:    w_next = i_rx_axis_tlast ? S_IDLE : S_SYNC;
        S_IDLE:    w_next = i_rx_axis_tlast ? S_IDLE : S_HDR1;
        S_HDR1:    w_next = i_rx_axis_tlast ? S_IDLE : S_PAYLOAD;
        S_PAYLOAD: w_next = i_rx_axis_tlast ? S_IDLE : S_DRAIN;
        S_DRAIN:   w_next = i_rx_axis_tlast ? S_IDLE : S_DRAIN;
        default:   w_next = S_SYNC;
      endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_mac_ok            <= 1'b0;
      r_type              <= '0;
      r_code              <= '0;
      r_chnl              <= '0;
      r_beats             <= '0;
      r_payload           <= '0;
      o_recv_time_stamp   <= '0;
      o_recv_ts_valid     <= 1'b0;
      o_recv_return_ts    <= '0;
      o_recv_return_valid <= 1'b0;
      o_recv_std_time     <= '0;
      o_recv_std_valid    <= 1'b0;
      o_chnl_ready        <= '0;
      o_cur_slot_id       <= 1'b0;
      o_syn_start         <= 1'b0;
      o_good_cnt          <= '0;
      o_drop_cnt          <= '0;
    end else begin
      o_recv_ts_valid     <= w_good && r_code == 8'h01;
      o_recv_return_valid <= w_good && r_code == 8'h02;
      o_recv_std_valid    <= w_good && r_code == 8'h03;
      if (i_rx_axis_tvalid && r_state == S_IDLE) begin
        r_mac_ok <= i_rx_axis_tdata[63:16] == P_MY_MAC || i_rx_axis_tdata[63:16] == 48'hFFFF_FFFF_FFFF;
        r_beats  <= 8'd1;
      end else if (i_rx_axis_tvalid && r_beats != 8'hFF)
        r_beats <= r_beats + 8'd1;
      if (i_rx_axis_tvalid && r_state == S_HDR1) begin
        r_type <= i_rx_axis_tdata[31:16];
        r_code <= i_rx_axis_tdata[15:8];
        r_chnl <= i_rx_axis_tdata[7:0];
      end
      if (i_rx_axis_tvalid && r_state == S_PAYLOAD) r_payload <= i_rx_axis_tdata;
      if (w_good && r_code == 8'h01) o_recv_time_stamp <= w_payload;
      if (w_good && r_code == 8'h02) o_recv_return_ts <= w_payload;
      if (w_good && r_code == 8'h03) o_recv_std_time <= w_payload;
      if (w_good && r_code == 8'h04) begin
        o_chnl_ready  <= r_chnl;
        o_cur_slot_id <= w_payload[0];
        o_syn_start   <= ~w_payload[0];
      end
      if (w_good && o_good_cnt != 16'hFFFF) o_good_cnt <= o_good_cnt + 16'd1;
      if (w_drop && o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
    end
endmodule

// File: tb/tb_ocs_ctrl_rx_parser.sv
// tb_ocs_ctrl_rx_parser: scoreboard bench for ocs_ctrl_rx_parser
module tb_ocs_ctrl_rx_parser;
  localparam logic [47:0] MY  = 48'h8DBC_5C4A_1A1F;
  localparam logic [47:0] BC  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC = 48'h0011_2233_4455;
  localparam logic [15:0] TYP = 16'hFF03;
  typedef struct {
    logic [2:0]  kind;
    logic [63:0] data;
    int          cyc;
  } exp_t;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
  logic [63:0] tdata = '0;
  logic [7:0]  tkeep = '0;
  logic [63:0] ts, ret, std;
  logic        ts_v, ret_v, std_v, slot, syn;
  logic [7:0]  chnl;
  logic [15:0] good, drop;
  exp_t        sb[$];
  int          checks = 0, errors = 0, cyc = 0;
  logic [15:0] exp_good = '0, exp_drop = '0;
  logic [7:0]  exp_chnl = '0;
  logic        exp_slot = 1'b0, exp_syn = 1'b0;
  ocs_ctrl_rx_parser dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rx_axis_tvalid(tvalid), .i_rx_axis_tdata(tdata), .i_rx_axis_tlast(tlast),
    .i_rx_axis_tkeep(tkeep), .i_rx_axis_tuser(tuser),
    .o_recv_time_stamp(ts), .o_recv_ts_valid(ts_v),
    .o_recv_return_ts(ret), .o_recv_return_valid(ret_v),
    .o_recv_std_time(std), .o_recv_std_valid(std_v),
    .o_chnl_ready(chnl), .o_cur_slot_id(slot), .o_syn_start(syn),
    .o_good_cnt(good), .o_drop_cnt(drop)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // every valid pulse must match the oldest expected result, on the expected cycle
  always @(negedge clk) begin
    logic [2:0] k;
    exp_t e;
    k = {std_v, ret_v, ts_v};
    if (k != 3'b000) begin
      if (sb.size() == 0) check("unexpected_valid", 64'(k), 64'd0);
      else begin
        e = sb.pop_front();
        check("valid_kind", 64'(k), 64'(e.kind));
        check("valid_cycle", 64'(cyc), 64'(e.cyc));
        check("valid_data", k[0] ? ts : k[1] ? ret : std, e.data);
      end
    end
  end
  task automatic drive(input logic v, input logic [63:0] d, input logic l, input logic u);
    @(negedge clk);
    tvalid = v;
    tdata  = d;
    tlast  = l;
    tuser  = u;
    tkeep  = l ? 8'h0F : 8'hFF;
  endtask
  // gap cycles carry garbage on every other signal
  task automatic idle(input int n);
    repeat (n) drive(1'b0, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
  endtask
  task automatic send_frame(input logic [47:0] dest, input logic [15:0] typ, input logic [7:0] code,
                            input logic [7:0] ch, input logic [63:0] pl, input int nb,
                            input logic user, input bit gaps);
    logic [63:0] b;
    bit ok;
    ok = (dest == MY || dest == BC) && typ == TYP && code >= 8'd1 && code <= 8'd4 && !user && nb >= 3;
    for (int i = 0; i < nb; i++) begin
      if (gaps && i > 0) idle($urandom_range(1, 3));
      b = (i == 0) ? {dest, SRC[47:32]} : (i == 1) ? {SRC[31:0], typ, code, ch} :
          (i == 2) ? pl : {$urandom, $urandom};
      drive(1'b1, b, i == nb - 1, (i == nb - 1) ? user : 1'($urandom));
    end
    if (ok) begin
      if (exp_good != 16'hFFFF) exp_good++;
      if (code == 8'd4) begin
        exp_chnl = ch;
        exp_slot = pl[0];
        exp_syn  = ~pl[0];
      end else sb.push_back('{3'b001 << (code - 8'd1), pl, cyc + 1});
    end else if (exp_drop != 16'hFFFF) exp_drop++;
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask
  task automatic settle(input string tag);
    idle(3);
    check({tag, "_pending"}, 64'(sb.size()), 64'd0);
    check({tag, "_good"}, 64'(good), 64'(exp_good));
    check({tag, "_drop"}, 64'(drop), 64'(exp_drop));
  endtask
  task automatic check_reset();
    check("rst_ts", ts, 64'd0);
    check("rst_ret", ret, 64'd0);
    check("rst_std", std, 64'd0);
    check("rst_valids", 64'({ts_v, ret_v, std_v}), 64'd0);
    check("rst_chnl", 64'(chnl), 64'd0);
    check("rst_slot_syn", 64'({slot, syn}), 64'd0);
    check("rst_good", 64'(good), 64'd0);
    check("rst_drop", 64'(drop), 64'd0);
  endtask
  task automatic sync_beat();
    drive(1'b1, {$urandom, $urandom}, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    // leftover tail of a frame seen out of reset is discarded without counting
    drive(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
    drive(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
    sync_beat();
    settle("sync");
    send_frame(MY, TYP, 8'h01, 8'h00, 64'h1234, 8, 1'b0, 1'b0);
    settle("code01");
    check("code01_ts", ts, 64'h1234);
    send_frame(MY, TYP, 8'h04, 8'hA5, 64'd1, 3, 1'b0, 1'b0);
    settle("code04_id1");
    check("code04_chnl", 64'(chnl), 64'(exp_chnl));
    check("code04_id1_slot", 64'(slot), 64'd1);
    check("code04_id1_syn", 64'(syn), 64'd0);
    send_frame(BC, TYP, 8'h04, 8'h3C, 64'hFFFF_0000_0000_0000, 5, 1'b0, 1'b1);
    settle("code04_id0");
    check("code04_id0_slot", 64'(slot), 64'd0);
    check("code04_id0_syn", 64'(syn), 64'(exp_syn));
    check("code04_chnl2", 64'(chnl), 64'h3C);
    send_frame(48'h8DBC_5C4A_1A1E, TYP, 8'h01, 8'h00, 64'h55, 4, 1'b0, 1'b0);
    send_frame(MY, 16'hFF02, 8'h02, 8'h00, 64'h66, 4, 1'b0, 1'b0);
    send_frame(MY, TYP, 8'h03, 8'h00, 64'h77, 6, 1'b1, 1'b0);
    send_frame(MY, TYP, 8'h01, 8'h00, 64'h88, 2, 1'b0, 1'b0);
    settle("drops");
    check("drops_total", 64'(drop), 64'd4);
    check("drops_ts_held", ts, 64'h1234);
    send_frame(MY, TYP, 8'h05, 8'h00, 64'h99, 3, 1'b0, 1'b0);
    send_frame(MY, TYP, 8'h00, 8'h00, 64'h9A, 3, 1'b0, 1'b0);
    send_frame(MY, TYP, 8'h01, 8'h00, 64'h9B, 1, 1'b0, 1'b0);
    settle("bad_code");
    send_frame(BC, TYP, 8'h03, 8'h00, 64'hFF00, 7, 1'b0, 1'b1);
    settle("code03_gaps");
    check("code03_std", std, 64'hFF00);
    for (int i = 0; i < 8; i++)
      send_frame($urandom_range(0, 1) ? MY : BC, TYP, 8'($urandom_range(1, 4)), 8'($urandom),
                 {$urandom, $urandom}, $urandom_range(3, 8), 1'b0, 1'($urandom_range(0, 1)));
    settle("random");
    // reset in the middle of a good frame: no pulse, no count, outputs cleared
    drive(1'b1, {MY, SRC[47:32]}, 1'b0, 1'b0);
    drive(1'b1, {SRC[31:0], TYP, 8'h01, 8'h00}, 1'b0, 1'b0);
    drive(1'b1, 64'hDEAD, 1'b0, 1'b0);
    drive(1'b1, 64'hBEEF, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    tvalid = 1'b0;
    exp_good = '0;
    exp_drop = '0;
    exp_chnl = '0;
    exp_slot = 1'b0;
    exp_syn  = 1'b0;
    repeat (2) @(negedge clk);
    check_reset();
    rst_n = 1'b1;
    for (int i = 4; i < 8; i++) drive(1'b1, {$urandom, $urandom}, i == 7, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    settle("midreset");
    send_frame(MY, TYP, 8'h02, 8'h00, 64'hCAFE_F00D_0000_0042, 8, 1'b0, 1'b0);
    settle("code02");
    check("code02_ret", ret, 64'hCAFE_F00D_0000_0042);
    // preload the good counter near the top to reach saturation in a few frames
    @(negedge clk);
    force dut.o_good_cnt = 16'hFFFD;
    @(negedge clk);
    release dut.o_good_cnt;
    exp_good = 16'hFFFD;
    for (int i = 0; i < 4; i++) send_frame(MY, TYP, 8'h01, 8'h00, 64'(i + 100), 3, 1'b0, 1'b0);
    settle("saturate");
    check("saturate_good", 64'(good), 64'hFFFF);
    check("saturate_ts", ts, 64'd103);
    idle(4);
    check("final_pending", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
